// File: rtl/processor_pkg.sv
// Shared definitions for the single-cycle accumulator processor.
// Holds default widths, opcode encodings and the ACC source-select encoding.
package processor_pkg;

  localparam int unsigned BITS_DEF   = 16;
  localparam int unsigned OPW        = 5;
  localparam int unsigned DTBITS_DEF = BITS_DEF - OPW;

  localparam logic [OPW-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPW-1:0] OP_STO  = 5'b00001;
  localparam logic [OPW-1:0] OP_LD   = 5'b00010;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPW-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPW-1:0] OP_SUBI = 5'b00111;

  // Source of the value loaded into ACC.
  typedef enum logic [1:0] {
    SELA_IMM = 2'd0,
    SELA_RAM = 2'd1,
    SELA_ALU = 2'd2
  } sel_a_e;

endpackage

// File: rtl/processor_control.sv
// Instruction decoder: maps the opcode to datapath controls.
// Ports:
//   opcode_i  - opcode field of the current instruction
//   wr_pc_o   - advance PC (0 only for HLT)
//   sel_a_o   - ACC load source (sel_a_e)
//   sel_b_o   - ALU operand B: 0 = data memory, 1 = sign-extended operand
//   wr_acc_o  - load ACC this cycle
//   op_o      - ALU operation: 0 = add, 1 = subtract
//   wr_o/rd_o - data-memory write strobe / read enable
module processor_control
  import processor_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output logic           wr_pc_o,
  output logic [1:0]     sel_a_o,
  output logic           sel_b_o,
  output logic           wr_acc_o,
  output logic           op_o,
  output logic           wr_o,
  output logic           rd_o
);

  // Defaults describe a NOP; each opcode overrides only what it needs.
  always_comb begin
    wr_pc_o  = 1'b1;
    sel_a_o  = SELA_ALU;
    sel_b_o  = 1'b0;
    wr_acc_o = 1'b0;
    op_o     = 1'b0;
    wr_o     = 1'b0;
    rd_o     = 1'b0;
    case (opcode_i)
      OP_HLT:  wr_pc_o = 1'b0;
      OP_STO:  wr_o    = 1'b1;
      OP_LD:   begin rd_o = 1'b1; sel_a_o = SELA_RAM; wr_acc_o = 1'b1; end
      OP_LDI:  begin sel_a_o = SELA_IMM; wr_acc_o = 1'b1; end
      OP_ADD:  begin rd_o = 1'b1; wr_acc_o = 1'b1; end
      OP_ADDI: begin sel_b_o = 1'b1; wr_acc_o = 1'b1; end
      OP_SUB:  begin rd_o = 1'b1; op_o = 1'b1; wr_acc_o = 1'b1; end
      OP_SUBI: begin sel_b_o = 1'b1; op_o = 1'b1; wr_acc_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/processor.sv
// Single-cycle accumulator processor: one instruction per clock, no pipeline.
// Ports:
//   i_clock, i_reset - clock and synchronous active-high reset
//   i_Data_rom       - instruction at o_Addr_rom (opcode | operand)
//   i_Data_ram       - data-memory read word at o_Addr_ram
//   o_Data_ram       - data-memory write word (ACC)
//   o_Addr_rom       - program address (PC)
//   o_Addr_ram       - data address (operand field)
//   Wr, Rd           - data-memory write strobe / read enable
module processor
  import processor_pkg::*;
#(
  parameter int unsigned BITS   = BITS_DEF,
  parameter int unsigned DTBITS = BITS - OPW
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [BITS-1:0]   i_Data_rom,
  input  logic [BITS-1:0]   i_Data_ram,
  output logic [BITS-1:0]   o_Data_ram,
  output logic [DTBITS-1:0] o_Addr_rom,
  output logic [DTBITS-1:0] o_Addr_ram,
  output logic              Wr,
  output logic              Rd
);

  logic [DTBITS-1:0] pc_q, pc_d;
  logic [BITS-1:0]   acc_q, acc_d;

  logic [OPW-1:0]    opcode;
  logic [DTBITS-1:0] operand;
  logic [BITS-1:0]   imm;
  logic [BITS-1:0]   alu_b;
  logic [BITS-1:0]   alu_res;
  logic [BITS-1:0]   acc_src;

  logic       wr_pc, sel_b, wr_acc, op, ctl_wr, ctl_rd;
  logic [1:0] sel_a;

  assign opcode  = OPW'(i_Data_rom[BITS-1:DTBITS]);
  assign operand = i_Data_rom[DTBITS-1:0];
  assign imm     = {{(BITS-DTBITS){operand[DTBITS-1]}}, operand};

  processor_control u_control (
    .opcode_i (opcode),
    .wr_pc_o  (wr_pc),
    .sel_a_o  (sel_a),
    .sel_b_o  (sel_b),
    .wr_acc_o (wr_acc),
    .op_o     (op),
    .wr_o     (ctl_wr),
    .rd_o     (ctl_rd)
  );

  // Add/sub datapath; wraps modulo 2^BITS, no flags.
  assign alu_b   = sel_b ? imm : i_Data_ram;
  assign alu_res = op ? (acc_q - alu_b) : (acc_q + alu_b);

  always_comb begin
    acc_src = alu_res;
    case (sel_a)
      SELA_IMM: acc_src = imm;
      SELA_RAM: acc_src = i_Data_ram;
      default:  acc_src = alu_res;
    endcase
  end

  // Next-state: HLT holds PC; PC wraps naturally at 2^DTBITS.
  always_comb begin
    acc_d = acc_q;
    pc_d  = pc_q;
    if (wr_acc) acc_d = acc_src;
    if (wr_pc)  pc_d  = pc_q + DTBITS'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q  <= '0;
      acc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
    end
  end

  assign o_Data_ram = acc_q;
  assign o_Addr_rom = pc_q;
  assign o_Addr_ram = operand;
  // Memory strobes are suppressed while reset is asserted.
  assign Wr = ctl_wr & ~i_reset;
  assign Rd = ctl_rd & ~i_reset;

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: a reference model pushes expected
// per-instruction results to a queue, observed results are queued alongside
// and each test task pops and compares them.
module tb_processor;

  logic        i_clock;
  logic        i_reset;
  logic [15:0] i_Data_rom;
  logic [15:0] i_Data_ram;
  logic [15:0] o_Data_ram;
  logic [10:0] o_Addr_rom;
  logic [10:0] o_Addr_ram;
  logic        Wr;
  logic        Rd;

  processor dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_Data_rom (i_Data_rom),
    .i_Data_ram (i_Data_ram),
    .o_Data_ram (o_Data_ram),
    .o_Addr_rom (o_Addr_rom),
    .o_Addr_ram (o_Addr_ram),
    .Wr         (Wr),
    .Rd         (Rd)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [10:0] addr_ram;
    logic [15:0] data_ram;
    logic [10:0] pc;
    logic [15:0] acc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  int tests = 0;
  int fails = 0;

  logic [10:0] mpc;
  logic [15:0] macc;

  // Drive one instruction; record model expectation and DUT observation.
  task automatic drive(input logic rst, input logic [15:0] instr, input logic [15:0] ram);
    rec_t e, o;
    logic [4:0]  opc;
    logic [15:0] sx;
    @(negedge i_clock);
    i_reset    = rst;
    i_Data_rom = instr;
    i_Data_ram = ram;
    #1;
    opc = instr[15:11];
    sx  = {{5{instr[10]}}, instr[10:0]};
    e = '0;
    e.addr_ram = instr[10:0];
    e.data_ram = macc;
    o.wr       = Wr;
    o.rd       = Rd;
    o.addr_ram = o_Addr_ram;
    o.data_ram = o_Data_ram;
    if (rst) begin
      mpc  = 11'd0;
      macc = 16'd0;
    end else begin
      e.wr = (opc == 5'd1);
      e.rd = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
      case (opc)
        5'd2: macc = ram;
        5'd3: macc = sx;
        5'd4: macc = macc + ram;
        5'd5: macc = macc + sx;
        5'd6: macc = macc - ram;
        5'd7: macc = macc - sx;
        default: ;
      endcase
      if (opc != 5'd0) mpc = mpc + 11'd1;
    end
    e.pc  = mpc;
    e.acc = macc;
    @(posedge i_clock);
    #1;
    o.pc  = o_Addr_rom;
    o.acc = o_Data_ram;
    exp_q.push_back(e);
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    rec_t e, o;
    i_reset = 1'b1; i_Data_rom = 16'h1000; i_Data_ram = 16'h1234;
    @(posedge i_clock); #1;
    mpc = 11'd0; macc = 16'd0;
    drive(1'b1, 16'h1000, 16'h1234);
    drive(1'b1, 16'h0801, 16'h5555);
    drive(1'b1, 16'h2001, 16'h0001);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset step: got wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h want wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h",
                 o.wr, o.rd, o.addr_ram, o.data_ram, o.pc, o.acc, e.wr, e.rd, e.addr_ram, e.data_ram, e.pc, e.acc);
      end
    end
    tests++;
    if (o_Addr_rom !== 11'd0 || o_Data_ram !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: got pc=%h acc=%h want pc=000 acc=0000", o_Addr_rom, o_Data_ram);
    end
  endtask

  task automatic test_program;
    rec_t e, o;
    drive(1'b0, 16'h0802, 16'h0001);
    drive(1'b0, 16'h1002, 16'h0001);
    drive(1'b0, 16'h1803, 16'h0001);
    drive(1'b0, 16'h2001, 16'h0001);
    drive(1'b0, 16'h2802, 16'h0001);
    drive(1'b0, 16'h3001, 16'h0001);
    drive(1'b0, 16'h3801, 16'h0001);
    drive(1'b0, 16'h0000, 16'h0001);
    drive(1'b0, 16'h0000, 16'h0001);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL program step: got wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h want wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h",
                 o.wr, o.rd, o.addr_ram, o.data_ram, o.pc, o.acc, e.wr, e.rd, e.addr_ram, e.data_ram, e.pc, e.acc);
      end
    end
    tests++;
    if (o_Addr_rom !== 11'd7 || o_Data_ram !== 16'd4 || Wr !== 1'b0 || Rd !== 1'b0) begin
      fails++;
      $display("FAIL halt_state: got pc=%h acc=%h wr=%b rd=%b want pc=007 acc=0004 wr=0 rd=0",
               o_Addr_rom, o_Data_ram, Wr, Rd);
    end
  endtask

  task automatic test_hlt_release;
    rec_t e, o;
    drive(1'b0, 16'h4000, 16'h0000);
    drive(1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 16'h0000, 16'h0000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL hlt_release step: got wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h want wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h",
                 o.wr, o.rd, o.addr_ram, o.data_ram, o.pc, o.acc, e.wr, e.rd, e.addr_ram, e.data_ram, e.pc, e.acc);
      end
    end
  endtask

  task automatic test_wrap;
    rec_t e, o;
    int n;
    logic [15:0] w;
    drive(1'b0, 16'h1FFF, 16'h0000);
    tests++;
    if (o_Data_ram !== 16'hFFFF) begin
      fails++;
      $display("FAIL ldi_sext: got acc=%h want FFFF", o_Data_ram);
    end
    drive(1'b0, 16'h2801, 16'h0000);
    tests++;
    if (o_Data_ram !== 16'h0000) begin
      fails++;
      $display("FAIL addi_wrap: got acc=%h want 0000", o_Data_ram);
    end
    n = 0;
    while (mpc != 11'h7FF && n < 3000) begin
      w = $urandom;
      w[15:11] = 5'(8 + $urandom_range(0, 23));
      drive(1'b0, w, 16'($urandom));
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL wrap_reach: got pc=%h want 7ff within budget", o_Addr_rom);
    end
    drive(1'b0, 16'h4000, 16'h0000);
    tests++;
    if (o_Addr_rom !== 11'd0) begin
      fails++;
      $display("FAIL pc_wrap: got pc=%h want 000", o_Addr_rom);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL wrap step: got wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h want wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h",
                 o.wr, o.rd, o.addr_ram, o.data_ram, o.pc, o.acc, e.wr, e.rd, e.addr_ram, e.data_ram, e.pc, e.acc);
      end
    end
  endtask

  task automatic test_random;
    rec_t e, o;
    logic [15:0] w;
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[15:11] = 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 15) == 0), w, 16'($urandom));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL random step: got wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h want wr=%b rd=%b ar=%h dr=%h pc=%h acc=%h",
                 o.wr, o.rd, o.addr_ram, o.data_ram, o.pc, o.acc, e.wr, e.rd, e.addr_ram, e.data_ram, e.pc, e.acc);
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_Data_rom = '0; i_Data_ram = '0;
    mpc = '0; macc = '0;
    test_reset;
    test_program;
    test_hlt_release;
    test_wrap;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
